// File: rtl/sub_pkg.sv
// sub_pkg: shared state encoding and default width for the serial subtractor
package sub_pkg;
    localparam int SUB_W = 8;
    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
endpackage

// File: rtl/full_sub4.sv
// full_sub4: 1-bit full-subtractor cell (d = difference bit, e = borrow out)
module full_sub4 (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic e
);
    assign d = a ^ b ^ bin;
    assign e = (~a & b) | (~a & bin) | (b & bin);
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a - b - bin, one bit per clock LSB first, around one full_sub4 cell
module serial_sub_ctrl
    import sub_pkg::*;
#(
    parameter int W = SUB_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow_out
);
    localparam int CNT_W = $clog2(W + 1);

    state_t           state, state_nxt;
    logic [W-1:0]     a_sh, b_sh;
    logic [W-2:0]     res;
    logic [CNT_W-1:0] cnt;
    logic             brw, d, e, load, fin;

    full_sub4 u_cell (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .bin(brw),
        .d  (d),
        .e  (e)
    );

    assign busy = (state == ST_SHIFT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Accept a start only when idle; finish on the last bit
    always_comb begin
        load      = (state == ST_IDLE) && start;
        fin       = (state == ST_SHIFT) && (cnt == CNT_W'(W - 1));
        state_nxt = load ? ST_SHIFT : fin ? ST_IDLE : state;
    end

    // Datapath: operand shifters, borrow flop, partial result and held outputs.
    // res only needs the W-1 earlier bits; the final bit comes straight from the cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            res        <= '0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            done <= fin;
            if (load) begin
                a_sh <= a;
                b_sh <= b;
                brw  <= bin;
                cnt  <= '0;
                res  <= '0;
            end else if (state == ST_SHIFT) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                brw  <= e;
                cnt  <= cnt + 1'b1;
                res  <= (W-1)'({d, res} >> 1);
            end
            if (fin) begin
                diff       <= {d, res};
                borrow_out <= e;
            end
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: scoreboard bench for the bit-serial subtractor
module tb_serial_sub_ctrl;
    import sub_pkg::*;
    localparam int W = 8;

    typedef struct {
        logic [W:0] exp;
        int         t0;
    } item_t;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, bin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, borrow_out;
    logic [W-1:0] diff;

    item_t      q[$];
    item_t      cur;
    int         checks = 0, errors = 0, cyc = 0;
    logic       prev_done = 1'b0;
    logic [W:0] last_res = '0;

    serial_sub_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrow_out(borrow_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor: pop expected result on each done, check latency, width and hold
    always @(negedge clk) begin
        if (!rst_n) begin
            last_res  = '0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                check("done_width", {8'h0, prev_done}, '0);
                if (q.size() == 0) begin
                    check("unexpected_done", {8'h0, done}, '0);
                end else begin
                    cur = q.pop_front();
                    check("result", {borrow_out, diff}, cur.exp);
                    check("latency", 9'(cyc - cur.t0), 9'(W));
                    last_res = {borrow_out, diff};
                end
            end else begin
                check("hold", {borrow_out, diff}, last_res);
            end
            prev_done = done;
        end
    end

    task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin, input bit track);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        if (busy) check("busy_timeout", {8'h0, busy}, '0);
        a     = ia;
        b     = ib;
        bin   = ibin;
        start = 1'b1;
        if (track) q.push_back('{exp: {1'b0, ia} - {1'b0, ib} - {8'h0, ibin}, t0: cyc + 1});
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        if (q.size() > 0) begin
            check("drain_timeout", 9'(q.size()), '0);
            q.delete();
        end
        tick();
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", {8'h0, busy}, '0);
        check("rst_done", {8'h0, done}, '0);
        check("rst_out", {borrow_out, diff}, '0);
        rst_n = 1'b1;
        tick();

        start_op(8'h35, 8'h12, 1'b0, 1'b1);
        check("busy_after_start", {8'h0, busy}, 9'h1);
        drain();
        start_op(8'h12, 8'h35, 1'b0, 1'b1);
        start_op(8'h00, 8'h01, 1'b0, 1'b1);
        start_op(8'h10, 8'h0F, 1'b1, 1'b1);
        start_op(8'hFF, 8'hFF, 1'b1, 1'b1);
        drain();

        // start held high with operands changed mid-operation: only the first op counts
        a     = 8'h35;
        b     = 8'h12;
        bin   = 1'b0;
        start = 1'b1;
        q.push_back('{exp: 9'h023, t0: cyc + 1});
        tick();
        tick();
        tick();
        a   = 8'hAA;
        b   = 8'h01;
        bin = 1'b1;
        tick();
        tick();
        start = 1'b0;
        drain();

        // start in the done cycle is accepted at once
        start_op(8'h80, 8'h01, 1'b0, 1'b1);
        for (int n = 0; n < 50 && !done; n++) tick();
        check("b2b_idle_in_done", {8'h0, busy}, '0);
        start_op(8'h01, 8'h80, 1'b1, 1'b1);
        drain();

        // reset mid-operation aborts without a done pulse
        start_op(8'h77, 8'h22, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("abort_busy", {8'h0, busy}, '0);
        check("abort_done", {8'h0, done}, '0);
        check("abort_out", {borrow_out, diff}, '0);
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) tick();
        start_op(8'h5A, 8'hA5, 1'b0, 1'b1);
        drain();

        for (int i = 0; i < 1000; i++)
            start_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
